// File: rtl/ads7816_responder.sv
// ads7816_responder: ADS7816 device-side serial responder driven by cs/dclock from an initiator
module ads7816_responder #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cs,
  input  logic             dclock,
  input  logic [WIDTH-1:0] sample,
  output logic             data,
  output logic             data_oe,
  output logic             busy,
  output logic             done,
  output logic [7:0]       frames
);
  localparam int NW = $clog2(2*WIDTH+3);
  localparam logic [NW-1:0] N_NULL    = NW'(2);
  localparam logic [NW-1:0] N_B0      = NW'(WIDTH+2);
  localparam logic [NW-1:0] N_LSB_END = NW'(2*WIDTH+1);
  localparam logic [NW-1:0] N_END     = NW'(2*WIDTH+2);

  typedef enum logic [2:0] {S_IDLE, S_SAMPLE, S_NULL, S_MSB, S_LSB, S_ZERO} state_t;

  state_t           state, state_nxt;
  logic [2:0]       cs_sy, dck_sy;
  logic             cs_fall, cs_rise, dck_fall;
  logic [NW-1:0]    n, n_nxt, n_inc, idx;
  logic [WIDTH-1:0] hold, hold_nxt, shifted;
  logic             data_nxt, oe_nxt, busy_nxt, done_nxt;
  logic [7:0]       frames_nxt;

  assign cs_fall  = cs_sy[2] & ~cs_sy[1];
  assign cs_rise  = ~cs_sy[2] & cs_sy[1];
  assign dck_fall = dck_sy[2] & ~dck_sy[1];

  // Next-state logic: abort beats frame start beats dclock fall; output for the new edge count is precomputed
  always_comb begin
    n_inc      = (n == N_END) ? n : n + 1'b1;
    idx        = (n_inc <= N_B0) ? N_B0 - n_inc : n_inc - N_B0;
    shifted    = hold >> idx;
    state_nxt  = state;
    n_nxt      = n;
    hold_nxt   = hold;
    data_nxt   = data;
    oe_nxt     = data_oe;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    frames_nxt = frames;
    if (cs_rise) begin
      state_nxt = S_IDLE;
      n_nxt     = '0;
      data_nxt  = 1'b0;
      oe_nxt    = 1'b0;
      busy_nxt  = 1'b0;
    end else if (cs_fall) begin
      state_nxt = S_SAMPLE;
      n_nxt     = '0;
      hold_nxt  = sample;
      data_nxt  = 1'b0;
      oe_nxt    = 1'b0;
      busy_nxt  = 1'b1;
    end else if (busy && dck_fall) begin
      n_nxt     = n_inc;
      state_nxt = n_inc < N_NULL    ? S_SAMPLE :
                  n_inc == N_NULL   ? S_NULL   :
                  n_inc <= N_B0     ? S_MSB    :
                  n_inc <= N_LSB_END ? S_LSB   : S_ZERO;
      oe_nxt    = n_inc >= N_NULL;
      data_nxt  = (state_nxt == S_MSB || state_nxt == S_LSB) & shifted[0];
      done_nxt  = n_inc == N_B0;
      frames_nxt = (n_inc == N_B0) ? frames + 8'd1 : frames;
    end
  end

  // Synchronizers, frame state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sy   <= 3'b111;
      dck_sy  <= 3'b000;
      state   <= S_IDLE;
      n       <= '0;
      hold    <= '0;
      data    <= 1'b0;
      data_oe <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      frames  <= 8'd0;
    end else begin
      cs_sy   <= {cs_sy[1:0], cs};
      dck_sy  <= {dck_sy[1:0], dclock};
      state   <= state_nxt;
      n       <= n_nxt;
      hold    <= hold_nxt;
      data    <= data_nxt;
      data_oe <= oe_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      frames  <= frames_nxt;
    end
  end
endmodule

// File: tb/tb_ads7816_responder.sv
// tb_ads7816_responder: scoreboard bench for the ADS7816 responder
module tb_ads7816_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b1;
  logic        dclock = 1'b1;
  logic [11:0] sample = 12'h000;
  logic        data, data_oe, busy, done;
  logic [7:0]  frames;
  int          n_checks = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  int          hp = 8;
  logic [11:0] cur_hold = 12'h000;
  logic [1:0]  sb[$];

  ads7816_responder #(.WIDTH(12)) dut (
    .clk(clk), .rst(rst), .cs(cs), .dclock(dclock), .sample(sample),
    .data(data), .data_oe(data_oe), .busy(busy), .done(done), .frames(frames)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] exp_out(input logic [11:0] h, input int n);
    logic [11:0] t;
    if (n < 2) return 2'b00;
    if (n == 2 || n >= 26) return 2'b10;
    t = (n <= 14) ? h >> (14 - n) : h >> (n - 14);
    return {1'b1, t[0]};
  endfunction

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #3;
  endtask

  task automatic dfall(input int i);
    dclock = 1'b0;
    sb.push_back(exp_out(cur_hold, i));
    tick(hp);
    dclock = 1'b1;
    tick(hp);
  endtask

  task automatic frame(input logic [11:0] s, input int nf, input bit sim, input int chg);
    sample = s;
    cur_hold = s;
    if (sim) begin
      cs = 1'b0;
      dclock = 1'b0;
      tick(hp);
      dclock = 1'b1;
      tick(hp);
    end else begin
      cs = 1'b0;
      tick(hp);
    end
    for (int i = 1; i <= nf; i++) begin
      if (i == chg) sample = ~s;
      dfall(i);
    end
    cs = 1'b1;
    tick(hp);
  endtask

  always @(posedge dclock)
    if (sb.size() > 0) check("bit", {30'b0, data_oe, data}, {30'b0, sb.pop_front()});

  always @(negedge clk)
    if (done) begin
      done_cnt++;
      check("done_b0", data, cur_hold[0]);
    end

  initial begin
    tick(4);
    check("rst_data", data, 0);
    check("rst_oe", data_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_frames", frames, 0);
    rst = 1'b0;
    tick(4);
    check("post_rst_busy", busy, 0);
    frame(12'hA5C, 14, 1'b0, 0);
    check("nom_done", done_cnt, 1);
    check("nom_frames", frames, 1);
    check("nom_busy", busy, 0);
    check("nom_oe", data_oe, 0);
    frame(12'hA5C, 30, 1'b0, 0);
    check("ext_done", done_cnt, 2);
    check("ext_frames", frames, 2);
    check("ext_oe", data_oe, 0);
    sample = 12'hA5C;
    cur_hold = 12'hA5C;
    cs = 1'b0;
    tick(hp);
    for (int i = 1; i <= 8; i++) dfall(i);
    cs = 1'b1;
    tick(2);
    check("abort_busy_pre", busy, 1);
    tick(1);
    check("abort_busy", busy, 0);
    check("abort_oe", data_oe, 0);
    check("abort_data", data, 0);
    check("abort_frames", frames, 2);
    check("abort_done", done_cnt, 2);
    tick(hp);
    frame(12'h001, 14, 1'b0, 0);
    check("after_abort_frames", frames, 3);
    frame(12'hFFF, 14, 1'b0, 5);
    check("iso_frames", frames, 4);
    for (int i = 0; i < 5; i++) begin
      dclock = 1'b0;
      tick(hp);
      check("idle_oe", data_oe, 0);
      check("idle_busy", busy, 0);
      dclock = 1'b1;
      tick(hp);
    end
    frame(12'h3C9, 14, 1'b1, 0);
    check("sim_frames", frames, 5);
    check("sim_done", done_cnt, 5);
    sample = 12'h6B2;
    cur_hold = 12'h6B2;
    cs = 1'b0;
    tick(hp);
    for (int i = 1; i <= 6; i++) dfall(i);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    tick(1);
    check("midrst_data", data, 0);
    check("midrst_oe", data_oe, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_frames", frames, 0);
    rst = 1'b0;
    tick(2);
    check("cslow_busy_early", busy, 0);
    tick(1);
    check("cslow_busy", busy, 1);
    for (int i = 1; i <= 14; i++) dfall(i);
    cs = 1'b1;
    tick(hp);
    check("cslow_frames", frames, 1);
    hp = 4;
    repeat (255) frame(12'($urandom), 14, 1'b0, 0);
    hp = 8;
    check("wrap_frames", frames, 0);
    check("wrap_done", done_cnt, 261);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
